i2s_tx_serializer: RTL and testbench

//   Drains 16-bit PCM words from the sample FIFO (fifo16x3) and serializes them as a

---
 rtl/i2s_tx_serializer_if.sv | 35 +++
 rtl/i2s_tx_serializer.sv | 91 +++++++++
 tb/tb_i2s_tx_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: groups the sample-FIFO read side and the I2S output pins
//   slave  : serializer view (pops the FIFO, drives bclk/lrck/sdata, underrun pulse)
//   master : environment view (FIFO model / pads / control)
//   With I2S_TX_UNDERRUN_CNT_EN defined, an 8-bit saturating underrun_count is added.
interface i2s_tx_serializer_if;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_read;
  logic [15:0] fifo_data;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0]  underrun_count;

  modport slave (
    input  enable, fifo_empty, fifo_data,
    output fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, underrun, underrun_count
  );
  modport master (
    output enable, fifo_empty, fifo_data,
    input  fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, underrun, underrun_count
  );
`else
  modport slave (
    input  enable, fifo_empty, fifo_data,
    output fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, underrun
  );
  modport master (
    output enable, fifo_empty, fifo_data,
    input  fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, underrun
  );
`endif
endinterface

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: pops 16-bit PCM words (L,R,L,R,...) from the sample FIFO and
//   serializes them as standard I2S (BCLK = clk/BCLK_DIV, LRCK period = 2*SLOT_BITS BCLKs).
// Ports: clk, reset (sync, active-high), bus (i2s_tx_serializer_if.slave: enable,
//   fifo_empty/fifo_read/fifo_data, i2s_bclk/i2s_lrck/i2s_sdata, underrun).
// Optional: define I2S_TX_UNDERRUN_CNT_EN for bus.underrun_count (saturating, reset-only clear).
module i2s_tx_serializer #(
  parameter int BCLK_DIV  = 4,   // even, >= 4
  parameter int SLOT_BITS = 16   // 16..32
) (
  input logic                clk,
  input logic                reset,
  i2s_tx_serializer_if.slave bus
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 slot;
  logic [SLOT_BITS-1:0] shifter;
  logic [15:0]          hold;
  logic                 capture;   // word popped last clk is on fifo_data now
  logic                 bclk_q;
  logic                 lrck_q;

  logic run;
  logic bit_edge;
  logic slot_start;
  logic div_wrap;
  logic bit_wrap;

  assign run        = bus.enable && !reset;
  assign bit_edge   = (div_cnt == '0);   // BCLK falling edge on the registered outputs
  assign slot_start = bit_edge && (bit_cnt == '0);
  assign div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign bit_wrap   = (bit_cnt == BIT_W'(SLOT_BITS - 1));

  // One fetch decision per slot; never pops an empty FIFO.
  assign bus.fifo_read = run && slot_start && !bus.fifo_empty;
  assign bus.underrun  = run && slot_start &&  bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (!run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      slot    <= 1'b0;
      shifter <= '0;
      hold    <= '0;
      capture <= 1'b0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        bit_cnt <= bit_wrap ? '0 : bit_cnt + BIT_W'(1);
        if (bit_wrap) slot <= ~slot;
      end

      bclk_q  <= (div_cnt >= DIV_W'(BCLK_DIV / 2));
      capture <= bus.fifo_read;

      // An empty fetch mutes the slot rather than replaying the previous word.
      if (bus.underrun)  hold <= '0;
      else if (capture)  hold <= bus.fifo_data;

      // Loading at bit 1 gives the I2S one-BCLK delay after the LRCK transition;
      // the shift at bit 0 of the next slot carries the LSB when SLOT_BITS is 16.
      if (bit_edge) begin
        lrck_q <= slot;
        if (bit_cnt == BIT_W'(1)) shifter <= SLOT_BITS'(hold) << (SLOT_BITS - 16);
        else                      shifter <= shifter << 1;
      end
    end
  end

  assign bus.i2s_bclk  = bclk_q;
  assign bus.i2s_lrck  = lrck_q;
  assign bus.i2s_sdata = shifter[SLOT_BITS-1];

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Survives enable toggles so firmware can read the total since reset.
  logic [7:0] urun_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                    urun_cnt <= '0;
    else if (bus.underrun && urun_cnt != 8'hFF)   urun_cnt <= urun_cnt + 8'd1;
  end

  assign bus.underrun_count = urun_cnt;
`endif
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: FIFO models feed a 16-bit-slot and a 32-bit-slot instance;
// expected (lrck,sdata) per BCLK rise and expected read/underrun clk stamps are queued
// with the stimulus and compared against what the negedge monitor collected.
module tb_i2s_tx_serializer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2s_tx_serializer_if bus16 ();
  i2s_tx_serializer_if bus32 ();

  i2s_tx_serializer #(.BCLK_DIV(4), .SLOT_BITS(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
  i2s_tx_serializer #(.BCLK_DIV(4), .SLOT_BITS(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  // FIFO models: main block owns write pointers, model blocks own read pointers.
  logic [15:0] mem16 [64];
  logic [15:0] mem32 [64];
  int wp16 = 0, rp16 = 0, wp32 = 0, rp32 = 0;

  assign bus16.fifo_empty = (wp16 == rp16);
  assign bus32.fifo_empty = (wp32 == rp32);

  always @(posedge clk) begin
    if (bus16.fifo_read) begin
      bus16.fifo_data <= mem16[rp16];
      rp16 <= rp16 + 1;
    end
    if (bus32.fifo_read) begin
      bus32.fifo_data <= mem32[rp32];
      rp32 <= rp32 + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  bit   mon = 1'b0;
  bit   sel32 = 1'b0;
  logic pb16 = 1'b0, pb32 = 1'b0;
  logic [1:0] obs[$];
  logic [1:0] expb[$];
  int rd[$], ur[$], erd[$], eur[$];

  always @(negedge clk) begin
    if (mon) begin
      if (sel32) begin
        if (bus32.i2s_bclk && !pb32) obs.push_back({bus32.i2s_lrck, bus32.i2s_sdata});
        if (bus32.fifo_read) rd.push_back(cyc);
        if (bus32.underrun)  ur.push_back(cyc);
      end else begin
        if (bus16.i2s_bclk && !pb16) obs.push_back({bus16.i2s_lrck, bus16.i2s_sdata});
        if (bus16.fifo_read) rd.push_back(cyc);
        if (bus16.underrun)  ur.push_back(cyc);
      end
    end
    pb16 = bus16.i2s_bclk;
    pb32 = bus32.i2s_bclk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic push16(input logic [15:0] w);
    mem16[wp16] = w;
    wp16++;
  endtask

  task automatic push32(input logic [15:0] w);
    mem32[wp32] = w;
    wp32++;
  endtask

  // Expected BCLK samples n = first..first+count-1 after enable: word bit j of slot k
  // appears at BCLK k*S + 1 + (15-j); slot 0 carries l, slot 1 carries r, later slots mute.
  task automatic push_bits(input int s, input logic [15:0] l, input logic [15:0] r,
                           input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      int k, i;
      logic sd;
      logic [15:0] w;
      sd = 1'b0;
      if (n >= 1) begin
        k = (n - 1) / s;
        i = (n - 1) % s;
        w = (k == 0) ? l : (k == 1) ? r : 16'h0000;
        if (i < 16) sd = w[15 - i];
      end
      expb.push_back({1'((n / s) % 2), sd});
    end
  endtask

  task automatic score(input string tag);
    int i;
    check({tag, "_bits_n"}, 32'(obs.size()), 32'(expb.size()));
    i = 0;
    while (obs.size() > 0 && expb.size() > 0) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(obs.pop_front()), 32'(expb.pop_front()));
      i++;
    end
    check({tag, "_rd_n"}, 32'(rd.size()), 32'(erd.size()));
    while (rd.size() > 0 && erd.size() > 0) check({tag, "_rd_t"}, 32'(rd.pop_front()), 32'(erd.pop_front()));
    check({tag, "_ur_n"}, 32'(ur.size()), 32'(eur.size()));
    while (ur.size() > 0 && eur.size() > 0) check({tag, "_ur_t"}, 32'(ur.pop_front()), 32'(eur.pop_front()));
    obs.delete(); expb.delete(); rd.delete(); ur.delete(); erd.delete(); eur.delete();
  endtask

  int t0, t1;

  initial begin
    reset = 1'b1;
    bus16.enable = 1'b0;
    bus32.enable = 1'b0;
    step(2);

    // 1: reset held with enable=1 and a non-empty FIFO
    push16(16'hA5F0);
    push16(16'h0F0F);
    mon = 1'b1;
    bus16.enable = 1'b1;
    step(3);
    check("t1_out16", 32'({bus16.i2s_bclk, bus16.i2s_lrck, bus16.i2s_sdata, bus16.underrun, bus16.fifo_read}), 32'd0);
    check("t1_out32", 32'({bus32.i2s_bclk, bus32.i2s_lrck, bus32.i2s_sdata, bus32.underrun, bus32.fifo_read}), 32'd0);
    check("t1_nopop", 32'(rp16), 32'd0);
    score("t1");

    // 2: L/R pair, enable active from the first clk after reset release
    reset = 1'b0;
    t0 = cyc;
    push_bits(16, 16'hA5F0, 16'h0F0F, 0, 49);
    erd.push_back(t0); erd.push_back(t0 + 64);
    eur.push_back(t0 + 128); eur.push_back(t0 + 192);
    wait_until(t0 + 196);
    bus16.enable = 1'b0;
    mon = 1'b0;
    score("t2");

    // 3: empty FIFO for 256 clks
    step(3);
    mon = 1'b1;
    bus16.enable = 1'b1;
    t0 = cyc;
    push_bits(16, 16'h0000, 16'h0000, 0, 64);
    for (int k = 0; k < 4; k++) eur.push_back(t0 + 64 * k);
    wait_until(t0 + 256);
    bus16.enable = 1'b0;
    mon = 1'b0;
    score("t3");

    // 4: enable dropped at clk 30 of a left slot, then re-enabled
    push16(16'hC3A5);
    push16(16'h5A5A);
    step(2);
    mon = 1'b1;
    bus16.enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + 30);
    bus16.enable = 1'b0;
    step(1);
    check("t4_idle_out", 32'({bus16.i2s_bclk, bus16.i2s_lrck, bus16.i2s_sdata}), 32'd0);
    wait_until(t0 + 100);
    mon = 1'b0;
    push_bits(16, 16'hC3A5, 16'h0000, 0, 7);
    erd.push_back(t0);
    score("t4a");
    check("t4_word_left", 32'(bus16.fifo_empty), 32'd0);
    mon = 1'b1;
    bus16.enable = 1'b1;
    t1 = cyc;
    push_bits(16, 16'h5A5A, 16'h0000, 0, 17);
    erd.push_back(t1);
    eur.push_back(t1 + 64);
    wait_until(t1 + 70);
    bus16.enable = 1'b0;
    mon = 1'b0;
    score("t4b");

    // 5: 32-bit slots
    push32(16'hFFFF);
    push32(16'h8001);
    step(2);
    sel32 = 1'b1;
    mon = 1'b1;
    bus32.enable = 1'b1;
    t0 = cyc;
    push_bits(32, 16'hFFFF, 16'h8001, 0, 65);
    erd.push_back(t0); erd.push_back(t0 + 128);
    eur.push_back(t0 + 256);
    wait_until(t0 + 262);
    bus32.enable = 1'b0;
    mon = 1'b0;
    score("t5");
    sel32 = 1'b0;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // 6: underrun counter saturation, survives enable, cleared by reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6_cnt_reset", 32'(bus16.underrun_count), 32'd0);
    bus16.enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + 640);
    check("t6_cnt_10", 32'(bus16.underrun_count), 32'd10);
    wait_until(t0 + 300 * 64);
    check("t6_cnt_sat", 32'(bus16.underrun_count), 32'hFF);
    bus16.enable = 1'b0;
    step(3);
    bus16.enable = 1'b1;
    step(70);
    bus16.enable = 1'b0;
    step(1);
    check("t6_cnt_hold", 32'(bus16.underrun_count), 32'hFF);
    reset = 1'b1;
    step(1);
    check("t6_cnt_clr", 32'(bus16.underrun_count), 32'd0);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
